pds_rx_port: RTL and testbench
==============================

Name: pds_rx_port

Overview:
Receive-side endpoint of the PDS packet interface; consumes the 16-bit packet word strobed out of the switch on data_op/valid_op. It decodes {source, target, data}, filters on its own target address (plus optional broadcast), and buffers accepted packets in a small FIFO. The FIFO feeds a downstream consumer over a valid/ready handshake. Drop events are tracked in saturating status counters.

Parameters:
MY_ADDR, 4'h1, target address this port accepts
DEPTH, 4, FIFO entries (power of 2, >= 2)
ACCEPT_BCAST, 1, when 1 also accept target == BCAST_ADDR (4'hF)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
data_op  input  16  packet word from switch: [15:12] source, [11:8] target, [7:0] data
valid_op  input  1  one-cycle strobe per packet word; back-to-back high = back-to-back packets
rx_source  output  4  source field of FIFO head
rx_data  output  8  data field of FIFO head
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts head when rx_valid && rx_ready
filt_cnt  output  8  packets discarded by address filter, saturating at 8'hFF
ovf_cnt  output  8  matching packets dropped because FIFO full, saturating at 8'hFF
fifo_level  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset == 0, asynchronous): capture register invalid, FIFO pointers and level 0, rx_valid 0, rx_source/rx_data 0, filt_cnt/ovf_cnt 0. Assertion mid-packet discards any in-flight capture and all buffered packets. Release is synchronous to clk; first sample happens on the first rising edge after release.
- Stage 1 (capture): at edge k with valid_op == 1, data_op is loaded into cap_word and cap_vld is set. cap_vld equals valid_op, registered every cycle. No backpressure to the switch; the port never stalls the input.
- Stage 2 (filter/write), with cap_vld == 1 at edge k+1:
  - match = (target == MY_ADDR) || (ACCEPT_BCAST && target == 4'hF).
  - !match: discard; filt_cnt++ (saturating).
  - match && space: push {source, data} into FIFO.
  - match && !space: discard; ovf_cnt++ (saturating). FIFO contents unchanged.
  - space = !full || pop_this_cycle. A simultaneous pop frees the slot; the push is accepted and the level is unchanged.
- Latency: valid_op high at edge k -> rx_valid high and head visible after edge k+1 (2 cycles) when the FIFO was empty.
- Output: rx_valid = (level != 0). rx_source/rx_data present the head combinationally from FIFO storage. pop = rx_valid && rx_ready. rx_ready while empty has no effect.
- Ordering: strict FIFO; the packet sampled first is presented first.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH; push and pop in the same cycle leave level unchanged.
- Counters saturate: 8'hFF stays 8'hFF and does not wrap. filt and ovf events cannot coincide in the same cycle.
- Broadcast when MY_ADDR == 4'hF: a single match, counted once.

Decomposition:
- pds_pkg: SRC_W=4, TGT_W=4, DATA_W=8, PKT_W=16, BCAST_ADDR=4'hF. Packed struct pds_pkt_t {source, target, data} whose layout matches data_op. Packed struct pds_rx_entry_t {source, data}.
- One sub-module, pds_rx_fifo: synchronous FIFO parameterized on DEPTH and entry type, with push/pop/full/empty/level and the same clk/reset. pds_rx_port instantiates it, plus the capture register, filter and counters.

Test Plan:
- Single match: MY_ADDR=1, strobe data_op=16'h31A5 -> 2 cycles later rx_valid=1, rx_source=3, rx_data=8'hA5. With rx_ready=1, rx_valid drops the next cycle; filt_cnt=ovf_cnt=0.
- Filter: strobe 16'h2255 (target 2) and 16'h2F66 (broadcast) with ACCEPT_BCAST=1 -> only 8'h66 emerges; filt_cnt=1. Repeat with ACCEPT_BCAST=0 -> nothing emerges; filt_cnt=2.
- Overflow: rx_ready=0, strobe 6 back-to-back matching packets with data 1..6, DEPTH=4 -> fifo_level=4, ovf_cnt=2. Draining yields data 1,2,3,4 in order.
- Full with simultaneous pop: FIFO full, rx_ready=1 on the cycle a matching packet reaches stage 2 -> packet accepted, level stays 4, ovf_cnt unchanged.
- Saturation: 300 non-matching strobes -> filt_cnt=8'hFF.
- Reset mid-operation: FIFO holding 3 entries plus a packet in the capture stage; drive reset=0 between edges -> rx_valid=0, level=0 and counters=0 immediately. After release, no stale packet appears.

Source files
------------

// File: rtl/pds_pkg.sv
// ---------------------------------------------------------------------------
// pds_pkg : field widths, packet/entry layouts and helpers for the PDS rx port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pds_pkg;

  localparam int SRC_W  = 4;
  localparam int TGT_W  = 4;
  localparam int DATA_W = 8;
  localparam int PKT_W  = SRC_W + TGT_W + DATA_W;
  localparam logic [TGT_W-1:0] BCAST_ADDR = 4'hF;

  // Field order matches the bit layout of data_op: [15:12] [11:8] [7:0]
  typedef struct packed {
    logic [SRC_W-1:0]  source;
    logic [TGT_W-1:0]  target;
    logic [DATA_W-1:0] data;
  } pds_pkt_t;

  typedef struct packed {
    logic [SRC_W-1:0]  source;
    logic [DATA_W-1:0] data;
  } pds_rx_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pds_rx_port_if.sv
// ---------------------------------------------------------------------------
// pds_rx_port_if : switch-side strobe input and consumer-side valid/ready head
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pds_rx_port_if;
  import pds_pkg::*;

  logic [PKT_W-1:0]  data_op;
  logic              valid_op;
  logic [SRC_W-1:0]  rx_source;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport slave (
    input  data_op, valid_op, rx_ready,
    output rx_source, rx_data, rx_valid
  );

  modport master (
    output data_op, valid_op, rx_ready,
    input  rx_source, rx_data, rx_valid
  );

endinterface

`default_nettype wire

// File: rtl/pds_rx_fifo.sv
// ---------------------------------------------------------------------------
// pds_rx_fifo : synchronous FIFO, head visible combinationally on dout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pds_rx_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [11:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          push,
  input  wire T              din,
  input  wire logic          pop,
  output T                   dout,
  output logic               full,
  output logic               empty,
  output logic [LW-1:0]      level
);

  T                mem_q [DEPTH];
  T                mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign push_ok = push && (!full || pop_ok);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/pds_rx_port.sv
// ---------------------------------------------------------------------------
// pds_rx_port : captures switch packets, filters on target, buffers in a FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pds_rx_port
  import pds_pkg::*;
#(
  parameter logic [3:0] MY_ADDR      = 4'h1,
  parameter int         DEPTH        = 4,
  parameter bit         ACCEPT_BCAST = 1'b1,
  localparam int        LW           = $clog2(DEPTH) + 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  pds_rx_port_if.slave       bus,
  output logic [7:0]         filt_cnt,
  output logic [7:0]         ovf_cnt,
  output logic [LW-1:0]      fifo_level
);

  logic [PKT_W-1:0] cap_word_q, cap_word_d;
  logic             cap_vld_q, cap_vld_d;
  logic [7:0]       filt_cnt_q, filt_cnt_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;

  pds_pkt_t         cap_pkt;
  pds_rx_entry_t    push_entry;
  pds_rx_entry_t    head_entry;
  logic             match;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             space;
  logic             push;
  logic             filt_ev;
  logic             ovf_ev;

  assign cap_pkt    = pds_pkt_t'(cap_word_q);
  // When MY_ADDR is itself the broadcast address this OR yields a single match
  assign match      = (cap_pkt.target == MY_ADDR) ||
                      (ACCEPT_BCAST && (cap_pkt.target == BCAST_ADDR));
  assign pop        = !fifo_empty && bus.rx_ready;
  assign space      = !fifo_full || pop;
  assign push       = cap_vld_q && match && space;
  assign filt_ev    = cap_vld_q && !match;
  assign ovf_ev     = cap_vld_q && match && !space;
  assign push_entry = '{source: cap_pkt.source, data: cap_pkt.data};

  always_comb begin
    cap_vld_d  = bus.valid_op;
    cap_word_d = bus.valid_op ? bus.data_op : cap_word_q;
    filt_cnt_d = filt_ev ? sat_inc8(filt_cnt_q) : filt_cnt_q;
    ovf_cnt_d  = ovf_ev  ? sat_inc8(ovf_cnt_q)  : ovf_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_vld_q  <= 1'b0;
      cap_word_q <= '0;
      filt_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      cap_vld_q  <= cap_vld_d;
      cap_word_q <= cap_word_d;
      filt_cnt_q <= filt_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  pds_rx_fifo #(
    .DEPTH (DEPTH),
    .T     (pds_rx_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.rx_valid  = !fifo_empty;
  assign bus.rx_source = head_entry.source;
  assign bus.rx_data   = head_entry.data;
  assign filt_cnt      = filt_cnt_q;
  assign ovf_cnt       = ovf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pds_rx_port.sv
// ---------------------------------------------------------------------------
// tb_pds_rx_port : scoreboard bench for pds_rx_port (broadcast on and off)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pds_rx_port;

  localparam int         DEPTH   = 4;
  localparam logic [3:0] MY_ADDR = 4'h1;
  localparam int         LW      = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [7:0]    filt_a, ovf_a, filt_b, ovf_b;
  logic [LW-1:0] level_a, level_b;

  pds_rx_port_if bus_a ();
  pds_rx_port_if bus_b ();

  assign bus_b.data_op  = bus_a.data_op;
  assign bus_b.valid_op = bus_a.valid_op;
  assign bus_b.rx_ready = 1'b1;

  pds_rx_port #(.MY_ADDR(MY_ADDR), .DEPTH(DEPTH), .ACCEPT_BCAST(1'b1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_a),
    .filt_cnt   (filt_a),
    .ovf_cnt    (ovf_a),
    .fifo_level (level_a)
  );

  pds_rx_port #(.MY_ADDR(MY_ADDR), .DEPTH(DEPTH), .ACCEPT_BCAST(1'b0)) u_dut_nb (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_b),
    .filt_cnt   (filt_b),
    .ovf_cnt    (ovf_b),
    .fifo_level (level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: expected entries enter the queue at stage 2, leave on pop
  logic [11:0] exp_q [$];
  logic        m_cap_vld;
  logic [15:0] m_cap;
  logic [7:0]  m_filt, m_ovf, m_bfilt;
  logic        check_en = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_cap_vld = 1'b0;
      m_cap     = '0;
      m_filt    = '0;
      m_ovf     = '0;
      m_bfilt   = '0;
    end else begin
      logic m_pop, m_push, m_match;
      m_pop   = (exp_q.size() != 0) && bus_a.rx_ready;
      m_match = (m_cap[11:8] == MY_ADDR) || (m_cap[11:8] == 4'hF);
      m_push  = 1'b0;
      if (m_cap_vld) begin
        if (!m_match)                                 m_filt = (m_filt == 8'hFF) ? m_filt : m_filt + 8'd1;
        else if ((exp_q.size() < DEPTH) || m_pop)     m_push = 1'b1;
        else                                          m_ovf  = (m_ovf == 8'hFF) ? m_ovf : m_ovf + 8'd1;
        if (m_cap[11:8] != MY_ADDR)                   m_bfilt = (m_bfilt == 8'hFF) ? m_bfilt : m_bfilt + 8'd1;
      end
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({m_cap[15:12], m_cap[7:0]});
      m_cap_vld = bus_a.valid_op;
      if (bus_a.valid_op) m_cap = bus_a.data_op;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (check_en) begin
      check("sb_rx_valid", 32'(bus_a.rx_valid), 32'(exp_q.size() != 0));
      check("sb_level",    32'(level_a),        32'(exp_q.size()));
      check("sb_filt",     32'(filt_a),         32'(m_filt));
      check("sb_ovf",      32'(ovf_a),          32'(m_ovf));
      check("sb_filt_nb",  32'(filt_b),         32'(m_bfilt));
      if (exp_q.size() != 0)
        check("sb_head", 32'({bus_a.rx_source, bus_a.rx_data}), 32'(exp_q[0]));
    end
  end

  task automatic drive(input logic [15:0] w);
    bus_a.data_op  = w;
    bus_a.valid_op = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus_a.valid_op = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset          = 1'b0;
    bus_a.data_op  = '0;
    bus_a.valid_op = 1'b0;
    bus_a.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_valid",  32'(bus_a.rx_valid),  32'd0);
    check("rst_rx_source", 32'(bus_a.rx_source), 32'd0);
    check("rst_rx_data",   32'(bus_a.rx_data),   32'd0);
    check("rst_level",     32'(level_a),         32'd0);
    check("rst_filt",      32'(filt_a),          32'd0);
    check("rst_ovf",       32'(ovf_a),           32'd0);
    reset    = 1'b1;
    check_en = 1'b1;
    idle(2);

    // Single matching packet: head visible two edges after the strobe
    drive(16'h31A5);
    idle(1);
    check("single_valid",  32'(bus_a.rx_valid),  32'd1);
    check("single_source", 32'(bus_a.rx_source), 32'd3);
    check("single_data",   32'(bus_a.rx_data),   32'hA5);
    bus_a.rx_ready = 1'b1;
    @(negedge clk);
    check("single_popped", 32'(bus_a.rx_valid), 32'd0);
    check("single_filt",   32'(filt_a),         32'd0);
    check("single_ovf",    32'(ovf_a),          32'd0);

    // Filter: non-matching target and broadcast
    drive(16'h2255);
    drive(16'h2F66);
    idle(3);
    check("filt_bcast_on",  32'(filt_a),         32'd1);
    check("filt_bcast_off", 32'(filt_b),         32'd2);
    check("filt_nb_empty",  32'(bus_b.rx_valid), 32'd0);

    // Overflow: six back-to-back matches into a four-entry FIFO
    bus_a.rx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) drive({8'h51, 8'(i)});
    idle(3);
    check("ovf_level", 32'(level_a), 32'd4);
    check("ovf_count", 32'(ovf_a),   32'd2);
    for (int i = 1; i <= 4; i++) begin
      bus_a.rx_ready = 1'b1;
      check("ovf_drain_order", 32'(bus_a.rx_data), 32'(i));
      @(negedge clk);
    end
    bus_a.rx_ready = 1'b0;
    check("ovf_drained", 32'(level_a), 32'd0);

    // Full FIFO with a pop in the same cycle the new packet reaches stage 2
    for (int i = 7; i <= 10; i++) drive({8'h51, 8'(i)});
    idle(2);
    check("full_level", 32'(level_a), 32'd4);
    drive(16'h510B);
    bus_a.valid_op = 1'b0;
    bus_a.rx_ready = 1'b1;
    @(negedge clk);
    bus_a.rx_ready = 1'b0;
    check("full_pop_level", 32'(level_a), 32'd4);
    check("full_pop_ovf",   32'(ovf_a),   32'd2);
    bus_a.rx_ready = 1'b1;
    idle(6);

    // Saturation of the filter counter
    for (int i = 0; i < 300; i++) drive({8'h42, 8'(i)});
    idle(2);
    check("sat_filt",    32'(filt_a), 32'hFF);
    check("sat_filt_nb", 32'(filt_b), 32'hFF);

    // Asynchronous reset with three buffered entries and one in capture
    bus_a.rx_ready = 1'b0;
    for (int i = 1; i <= 3; i++) drive({8'h71, 8'(8'h20 + i)});
    bus_a.data_op  = 16'h7124;
    bus_a.valid_op = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_level", 32'(level_a), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    check("arst_rx_valid", 32'(bus_a.rx_valid), 32'd0);
    check("arst_level",    32'(level_a),        32'd0);
    check("arst_filt",     32'(filt_a),         32'd0);
    check("arst_ovf",      32'(ovf_a),          32'd0);
    check("arst_rx_data",  32'(bus_a.rx_data),  32'd0);
    @(negedge clk);
    bus_a.valid_op = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    check("post_rst_valid", 32'(bus_a.rx_valid), 32'd0);
    check("post_rst_level", 32'(level_a),        32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
